// File: rtl/vx_fetch_arbiter.sv
// Round-robin fetch scheduler: picks one eligible warp per cycle, registers its
// wid/PC/tmask/uuid for the fetch unit and locks the warp until its fetch response.
module vx_fetch_arbiter #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int PC_BITS     = 30,
    parameter int UUID_WIDTH  = 16,
    parameter int NW_WIDTH    = $clog2(NUM_WARPS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_WARPS-1:0]             req_valid,
    input  logic [NUM_WARPS*PC_BITS-1:0]     req_pc,
    input  logic [NUM_WARPS*NUM_THREADS-1:0] req_tmask,
    output logic [NUM_WARPS-1:0]             req_ready,
    output logic                             out_valid,
    output logic [NW_WIDTH-1:0]              out_wid,
    output logic [PC_BITS-1:0]               out_pc,
    output logic [NUM_THREADS-1:0]           out_tmask,
    output logic [UUID_WIDTH-1:0]            out_uuid,
    input  logic                             out_ready,
    input  logic                             rsp_valid,
    input  logic [NW_WIDTH-1:0]              rsp_wid,
    output logic                             busy,
    output logic                             err
);

    logic [NUM_WARPS-1:0]  inflight;
    logic [NUM_WARPS-1:0]  inflight_next;
    logic [NUM_WARPS-1:0]  eligible;
    logic [NW_WIDTH-1:0]   rr_last;
    logic [UUID_WIDTH-1:0] uuid_cnt;
    logic [NW_WIDTH-1:0]   grant_wid;
    logic                  grant_any;
    logic                  grant;
    logic                  load;
    logic                  rsp_hit;
    logic                  rsp_bad;

    assign eligible = req_valid & ~inflight;
    assign load     = ~out_valid | out_ready;
    // Gated by reset so no request is reported consumed while the block is held in reset.
    assign grant    = load & grant_any & ~reset;
    assign rsp_hit  = rsp_valid & inflight[rsp_wid];
    assign rsp_bad  = rsp_valid & ~inflight[rsp_wid];
    assign busy     = (|inflight) | out_valid;

    // Scan rr_last+1 .. rr_last+NUM_WARPS; the last step wraps back to rr_last itself.
    always_comb begin
        logic [NW_WIDTH-1:0] idx;
        // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
        grant_any = 1'b0;
        grant_wid = '0;
        idx       = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            idx = rr_last + NW_WIDTH'(i);
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_wid = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            req_ready[w] = grant && (grant_wid == NW_WIDTH'(w));
        end
    end

    // Grant and response never target the same warp, so the order of these two updates is free.
    always_comb begin
        inflight_next = inflight;
        if (rsp_hit) inflight_next[rsp_wid] = 1'b0;
        if (grant)   inflight_next[grant_wid] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            inflight <= inflight_next;
            if (rsp_bad) err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_wid   <= '0;
            out_pc    <= '0;
            out_tmask <= '0;
            out_uuid  <= '0;
            uuid_cnt  <= '0;
            rr_last   <= NW_WIDTH'(NUM_WARPS - 1);
        end else if (load) begin
            out_valid <= grant;
            if (grant) begin
                out_wid   <= grant_wid;
                out_pc    <= req_pc[int'(grant_wid)*PC_BITS +: PC_BITS];
                out_tmask <= req_tmask[int'(grant_wid)*NUM_THREADS +: NUM_THREADS];
                out_uuid  <= uuid_cnt;
                uuid_cnt  <= uuid_cnt + UUID_WIDTH'(1);
                rr_last   <= grant_wid;
            end
        end
    end

endmodule

// File: tb/tb_vx_fetch_arbiter.sv
// Directed bench for vx_fetch_arbiter: round-robin order, lock/release, stall hold,
// error flag, uuid wrap and asynchronous reset.
module tb_vx_fetch_arbiter;

    localparam int NW  = 4;
    localparam int NT  = 4;
    localparam int PCB = 30;
    localparam int UW  = 16;
    localparam int NWW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NW-1:0]    req_valid;
    logic [NW*PCB-1:0] req_pc;
    logic [NW*NT-1:0] req_tmask;
    logic [NW-1:0]    req_ready;
    logic             out_valid;
    logic [NWW-1:0]   out_wid;
    logic [PCB-1:0]   out_pc;
    logic [NT-1:0]    out_tmask;
    logic [UW-1:0]    out_uuid;
    logic             out_ready;
    logic             rsp_valid;
    logic [NWW-1:0]   rsp_wid;
    logic             busy;
    logic             err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vx_fetch_arbiter #(
        .NUM_WARPS(NW), .NUM_THREADS(NT), .PC_BITS(PCB), .UUID_WIDTH(UW), .NW_WIDTH(NWW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_pc(req_pc), .req_tmask(req_tmask), .req_ready(req_ready),
        .out_valid(out_valid), .out_wid(out_wid), .out_pc(out_pc), .out_tmask(out_tmask),
        .out_uuid(out_uuid), .out_ready(out_ready),
        .rsp_valid(rsp_valid), .rsp_wid(rsp_wid), .busy(busy), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Expected pc is 0x100+wid and tmask is wid+1, as loaded in the initial block.
    task automatic expect_out(input string tag, input int wid, input int uuid);
        check({tag, ".valid"}, 32'(out_valid), 1);
        check({tag, ".wid"},   32'(out_wid),   wid);
        check({tag, ".pc"},    32'(out_pc),    32'h100 + wid);
        check({tag, ".tmask"}, 32'(out_tmask), wid + 1);
        check({tag, ".uuid"},  32'(out_uuid),  uuid);
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int grants;
        reset     = 1'b1;
        req_valid = 4'hF;
        out_ready = 1'b1;
        rsp_valid = 1'b0;
        rsp_wid   = '0;
        for (int w = 0; w < NW; w++) begin
            req_pc[w*PCB +: PCB]  = PCB'(32'h100 + w);
            req_tmask[w*NT +: NT] = NT'(w + 1);
        end

        // Reset state, with all requests asserted to show grants are suppressed.
        next_cycle(); #1;
        check("rst.out_valid", 32'(out_valid), 0);
        check("rst.req_ready", 32'(req_ready), 0);
        check("rst.busy",      32'(busy),      0);
        check("rst.err",       32'(err),       0);
        check("rst.wid",       32'(out_wid),   0);
        check("rst.pc",        32'(out_pc),    0);
        check("rst.tmask",     32'(out_tmask), 0);
        check("rst.uuid",      32'(out_uuid),  0);

        // Cycles 0..3: grants 0,1,2,3 back to back.
        next_cycle(); reset = 1'b0; #1;
        check("c0.req_ready", 32'(req_ready), 32'h1);
        for (int k = 1; k < 4; k++) begin
            next_cycle(); #1;
            check("rr.req_ready", 32'(req_ready), 32'h1 << k);
            expect_out("rr.out", k - 1, k - 1);
        end
        next_cycle(); #1;
        check("c4.req_ready", 32'(req_ready), 0);
        check("c4.busy",      32'(busy),      1);
        expect_out("c4.out", 3, 3);

        // Cycle 5: response for warp 2; re-grant appears in cycle 6.
        next_cycle(); rsp_valid = 1'b1; rsp_wid = 2'd2; #1;
        check("c5.out_valid", 32'(out_valid), 0);
        check("c5.busy",      32'(busy),      1);
        check("c5.req_ready", 32'(req_ready), 0);
        next_cycle(); rsp_valid = 1'b0; #1;
        check("c6.req_ready", 32'(req_ready), 32'h4);

        // Cycle 7: warp 2 presented with uuid 4; release warp 1.
        next_cycle(); rsp_valid = 1'b1; rsp_wid = 2'd1; #1;
        expect_out("c7.out", 2, 4);
        check("c7.req_ready", 32'(req_ready), 0);
        check("c7.err",       32'(err),       0);
        next_cycle(); rsp_valid = 1'b0; #1;
        check("c8.out_valid", 32'(out_valid), 0);
        check("c8.req_ready", 32'(req_ready), 32'h2);

        // Cycles 9..11: stall with warp 1 on the output; release warps 3 and 0 meanwhile.
        next_cycle(); out_ready = 1'b0; rsp_valid = 1'b1; rsp_wid = 2'd3; #1;
        expect_out("stall0", 1, 5);
        check("stall0.req_ready", 32'(req_ready), 0);
        next_cycle(); rsp_wid = 2'd0; #1;
        expect_out("stall1", 1, 5);
        check("stall1.req_ready", 32'(req_ready), 0);
        next_cycle(); rsp_valid = 1'b0; #1;
        expect_out("stall2", 1, 5);
        check("stall2.req_ready", 32'(req_ready), 0);

        // Cycle 12: accepted; round robin after warp 1 skips busy warp 2 and picks 3, then 0.
        next_cycle(); out_ready = 1'b1; #1;
        expect_out("rel.out", 1, 5);
        check("rel.req_ready", 32'(req_ready), 32'h8);
        next_cycle(); #1;
        expect_out("rel1.out", 3, 6);
        check("rel1.req_ready", 32'(req_ready), 32'h1);
        next_cycle(); #1;
        expect_out("rel2.out", 0, 7);
        check("rel2.req_ready", 32'(req_ready), 0);
        check("rel2.err",       32'(err),       0);

        // Fresh start: set rr_last=1, then warps 1 and 3 both eligible.
        next_cycle(); reset = 1'b1; req_valid = 4'h0;
        next_cycle(); reset = 1'b0; req_valid = 4'h2; #1;
        check("rrA.req_ready", 32'(req_ready), 32'h2);
        next_cycle(); req_valid = 4'h0; rsp_valid = 1'b1; rsp_wid = 2'd1; #1;
        expect_out("rrA1.out", 1, 0);
        next_cycle(); rsp_valid = 1'b0; req_valid = 4'hA; #1;
        check("rrA2.req_ready", 32'(req_ready), 32'h8);
        next_cycle(); #1;
        expect_out("rrA3.out", 3, 1);
        check("rrA3.req_ready", 32'(req_ready), 32'h2);
        next_cycle(); req_valid = 4'h0; #1;
        expect_out("rrA4.out", 1, 2);

        // Response for idle warp 0: sticky err, no change to the in-flight set.
        next_cycle(); rsp_valid = 1'b1; rsp_wid = 2'd0; #1;
        check("err0.err",       32'(err),       0);
        check("err0.out_valid", 32'(out_valid), 0);
        next_cycle(); rsp_valid = 1'b0; req_valid = 4'hA; #1;
        check("err1.err",       32'(err),       1);
        check("err1.req_ready", 32'(req_ready), 0);
        next_cycle(); req_valid = 4'h1; #1;
        check("err2.req_ready", 32'(req_ready), 32'h1);
        check("err2.err",       32'(err),       1);
        next_cycle(); req_valid = 4'h0; #1;
        expect_out("err3.out", 0, 3);
        check("err3.busy", 32'(busy), 1);
        check("err3.err",  32'(err),  1);

        // Asynchronous reset between clock edges.
        #2; req_valid = 4'hF; reset = 1'b1; #1;
        check("areset.out_valid", 32'(out_valid), 0);
        check("areset.busy",      32'(busy),      0);
        check("areset.req_ready", 32'(req_ready), 0);
        check("areset.err",       32'(err),       0);
        next_cycle(); reset = 1'b0; #1;
        check("areset.first",     32'(req_ready), 32'h1);
        check("areset.busy_rel",  32'(busy),      0);

        // Stream with immediate responses: one grant per cycle until uuid wraps.
        grants = 0;
        for (int k = 0; k < 65536; k++) begin
            if (k > 0) next_cycle();
            rsp_valid = out_valid;
            rsp_wid   = out_wid;
            #1;
            if (req_ready != 4'h0) grants++;
        end
        check("stream.grants", 32'(grants), 65536);
        next_cycle(); rsp_valid = out_valid; rsp_wid = out_wid; #1;
        check("wrap0.valid", 32'(out_valid), 1);
        check("wrap0.uuid",  32'(out_uuid),  32'hFFFF);
        check("wrap0.wid",   32'(out_wid),   3);
        next_cycle(); rsp_valid = out_valid; rsp_wid = out_wid; #1;
        check("wrap1.uuid",  32'(out_uuid),  0);
        check("wrap1.wid",   32'(out_wid),   0);
        check("wrap1.err",   32'(err),       0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
